i2s_sample_feeder: RTL and testbench
====================================

Name: i2s_sample_feeder

Overview:
- Upstream stage of the I2S transmitter.
- Buffers 16-bit left-channel samples from the processing chain in a small FIFO.
- Presents exactly one new sample per I2S frame on `sound_out`, which drives the transmitter's `sound_in`.
- Frame timing comes from the transmitter's `word_select`. `sound_out` is updated only just after the transmitter has latched the previous sample, so it is stable for the entire frame.

Parameters:
- SAMPLE_W, 16: sample width in bits; must match the transmitter.
- DEPTH, 16: FIFO entries; power of two, minimum 4.
- PRIME_LEVEL, 4: FIFO level required before playback starts; range 1..DEPTH.

Ports:
- serial_clk  in  1  bit clock (3.072 MHz); same clock as the transmitter.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the FIFO; returns the block to PRIME.
- in_sample  in  SAMPLE_W  sample from the processing chain.
- in_valid  in  1  `in_sample` is valid.
- in_ready  out  1  block can accept a sample.
- word_select  in  1  `word_select` output of the transmitter.
- sound_out  out  SAMPLE_W  sample presented to transmitter `sound_in`.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- playing  out  1  high in RUN state.
- underrun_count  out  16  saturating count of frames with no sample available.

Behaviour:
- Clock and reset: single clock `serial_clk`; `reset` is asynchronous, active-low.
- Reset values:
  - `sound_out` = 0, `fifo_level` = 0, `playing` = 0, `underrun_count` = 0.
  - Read and write pointers = 0; state = PRIME; `ws_d` = 0.
- Write side:
  - `in_ready` = !full && !flush, combinational from the registered level.
  - A push occurs when `in_valid && in_ready`; the sample is written at `wr_ptr` and `wr_ptr` increments, wrapping modulo DEPTH.
- Frame event:
  - `ws_d` registers `word_select`. `frame_evt` = `ws_d & ~word_select` (the 1->0 transition).
  - `frame_evt` is true in the cycle after the edge at which the transmitter latched `sound_in`.
  - The pop happens on the next edge, so `sound_out` changes once per 64 clocks, 1 clock after the latch. It is stable for the following 63 clocks.
- State machine:
  - PRIME:
    - `playing` = 0; no pops.
    - On `frame_evt`: if `fifo_level` >= PRIME_LEVEL, pop the head into `sound_out` and go to RUN.
    - Otherwise `sound_out` <= 0 and there is no underrun count.
  - RUN:
    - `playing` = 1.
    - On `frame_evt` with the FIFO non-empty: `sound_out` <= `mem[rd_ptr]`; `rd_ptr` increments and wraps.
    - On `frame_evt` with the FIFO empty: underrun. `sound_out` gets the underrun value (see Optional Feature). `underrun_count` increments, saturating at 0xFFFF. State stays RUN.
- Level: `fifo_level` = previous + push − pop. A simultaneous push and pop leaves the level unchanged.
  - Full: `in_ready` = 0. A pop in that cycle does not re-open ready until the next cycle.
  - Empty: no fall-through. A push and an underrun pop in the same cycle is an underrun; the pushed sample is played next frame.
- flush:
  - Pointers and level go to 0, `sound_out` <= 0, state goes to PRIME.
  - `underrun_count` is preserved.
  - flush overrides any simultaneous push or pop; the push is dropped because `in_ready` = 0.
- Reset mid-frame: all state clears immediately. Output is 0 until a new PRIME completes.

Optional Feature:
- Macro: I2S_FEEDER_HOLD_LAST_EN.
- Defined: on a RUN underrun, `sound_out` keeps its previous value (repeat last sample).
- Undefined: on a RUN underrun, `sound_out` <= 0 (silence).
- The underrun count is identical in both builds.

Decomposition:
- Package `audio_pkg`:
  - `SAMPLE_W` localparam and `sample_t` typedef (`logic [SAMPLE_W-1:0]`).
  - `feeder_state_t` enum {PRIME, RUN}.
  - `FRAME_BITS` = 32; `UNDERRUN_MAX` = 16'hFFFF.
- Sub-module `audio_sync_fifo`: memory array, pointers, level, full and empty flags.
- The feeder top holds edge detection, the FSM, the output register and the counter.

Test Plan:
- Reset then push 3 samples, PRIME_LEVEL = 4 -> `sound_out` stays 0 across 3 frames, `playing` = 0, `underrun_count` = 0.
- Push 0x1111, 0x2222, 0x3333, 0x4444, then run frames -> `sound_out` = 0x1111 exactly one clock after the first ws 1->0 edge, then 0x2222 the next frame. `sound_out` is constant between events and the transmitter serializes each value MSB-first.
- Fill FIFO to 16 with `in_valid` held high -> `in_ready` = 0 at level 16. A 17th sample is not accepted; `fifo_level` does not exceed 16.
- Drain in RUN with no pushes -> after the last sample, each frame increments `underrun_count`. `sound_out` = 0 without the macro, or holds the last sample with I2S_FEEDER_HOLD_LAST_EN.
- flush asserted with `in_valid` = 1 in the same cycle as `frame_evt` -> level 0, state PRIME, `sound_out` = 0, push dropped, `underrun_count` unchanged.
- Assert `reset` low mid-frame with the FIFO at level 5 -> all outputs go to reset values immediately. The PRIME sequence restarts after `reset` is released.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types and constants for the I2S sample feeder.
package audio_pkg;

  localparam int          SAMPLE_W     = 16;
  localparam int          FRAME_BITS   = 32;
  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } feeder_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == UNDERRUN_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock sample FIFO with registered occupancy, full and empty flags.
// Head entry is presented combinationally on rdata_o (no fall-through on empty).
module audio_sync_fifo
  import audio_pkg::*;
#(
  parameter int W     = SAMPLE_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/i2s_sample_feeder.sv
// Feeds one buffered sample per I2S frame to the transmitter, timed off word_select.
// Optional: I2S_FEEDER_HOLD_LAST_EN repeats the last sample on underrun instead of silence.
//   state | meaning
//   PRIME | filling FIFO, output silent, waiting for PRIME_LEVEL at a frame event
//   RUN   | one pop per frame event; empty FIFO at a frame event is an underrun
module i2s_sample_feeder
  import audio_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                     serial_clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [SAMPLE_W-1:0]      in_sample,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     word_select,
  output logic [SAMPLE_W-1:0]      sound_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     playing,
  output logic [15:0]              underrun_count
);

  localparam int            LW        = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  sample_t       head;
  logic          full, empty;
  logic          push, pop, frame_evt;

  logic          ws_q;
  feeder_state_t state_q;
  sample_t       sound_q;
  logic          playing_q;
  logic [15:0]   underrun_q;

  // Falling word_select: the transmitter has just latched the current sample.
  assign frame_evt = ws_q & ~word_select;
  assign in_ready  = !full && !flush;
  assign push      = in_valid && in_ready;

  always_comb begin
    pop = 1'b0;
    if (frame_evt && !flush) begin
      pop = (state_q == PRIME) ? (fifo_level >= PRIME_LVL) : !empty;
    end
  end

  audio_sync_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (serial_clk),
    .rst_ni  (reset),
    .clear_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_sample),
    .rdata_o (head),
    .level_o (fifo_level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      ws_q       <= 1'b0;
      state_q    <= PRIME;
      sound_q    <= '0;
      playing_q  <= 1'b0;
      underrun_q <= '0;
    end else begin
      ws_q <= word_select;
      if (flush) begin
        // Underrun history survives a flush on purpose.
        state_q   <= PRIME;
        sound_q   <= '0;
        playing_q <= 1'b0;
      end else if (frame_evt) begin
        case (state_q)
          PRIME: begin
            if (fifo_level >= PRIME_LVL) begin
              sound_q   <= head;
              state_q   <= RUN;
              playing_q <= 1'b1;
            end else begin
              sound_q <= '0;
            end
          end
          RUN: begin
            if (!empty) begin
              sound_q <= head;
            end else begin
              underrun_q <= sat_inc16(underrun_q);
`ifdef I2S_FEEDER_HOLD_LAST_EN
              sound_q <= sound_q;
`else
              sound_q <= '0;
`endif
            end
          end
          default: begin
            state_q   <= PRIME;
            playing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sound_out      = sound_q;
  assign playing        = playing_q;
  assign underrun_count = underrun_q;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Self-checking bench for i2s_sample_feeder against a queue-based frame model.
module tb_i2s_sample_feeder;
  import audio_pkg::*;

  localparam int DEPTH = 16;
  localparam int PL    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 2 * FRAME_BITS;

  logic                serial_clk = 1'b0;
  logic                reset = 1'b0;
  logic                flush = 1'b0;
  logic [SAMPLE_W-1:0] in_sample = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                word_select = 1'b0;
  logic [SAMPLE_W-1:0] sound_out;
  logic [LW-1:0]       fifo_level;
  logic                playing;
  logic [15:0]         underrun_count;

  i2s_sample_feeder #(.DEPTH(DEPTH), .PRIME_LEVEL(PL)) dut (
    .serial_clk     (serial_clk),
    .reset          (reset),
    .flush          (flush),
    .in_sample      (in_sample),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .word_select    (word_select),
    .sound_out      (sound_out),
    .fifo_level     (fifo_level),
    .playing        (playing),
    .underrun_count (underrun_count)
  );

  always #5 serial_clk = ~serial_clk;

  // Reference model: sample queue plus play/underrun bookkeeping per frame.
  logic [15:0] q[$];
  logic [15:0] acc[$];
  bit          m_run;
  logic [15:0] m_sound;
  logic [15:0] m_und;
  bit          m_ws_prev;
  int          phase;
  bit          ws_run;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [38:0] dut_vec();
    return {sound_out, fifo_level, playing, underrun_count, in_ready};
  endfunction

  function automatic logic [38:0] mdl_vec();
    logic [LW-1:0] lvl;
    logic          rdy;
    lvl = LW'(q.size());
    rdy = (q.size() < DEPTH) && !flush;
    return {m_sound, lvl, m_run, m_und, rdy};
  endfunction

  task automatic model_reset();
    q.delete();
    m_run = 0;
    m_sound = '0;
    m_und = '0;
    m_ws_prev = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    in_sample = '0;
    word_select = 1'b0;
    model_reset();
    phase = 0;
    repeat (2) @(posedge serial_clk);
    #1 reset = 1'b1;
  endtask

  // One clock: drive inputs, advance the model at the edge, return 1 unit after it.
  task automatic cyc(input bit v, input logic [15:0] d, input bit fl);
    int pre;
    bit rdy, push, frame;
    in_valid = v;
    in_sample = d;
    flush = fl;
    if (ws_run) word_select = (phase >= FRAME_BITS);
    rdy = (q.size() < DEPTH) && !fl;
    push = v && rdy;
    frame = m_ws_prev && !word_select;
    pre = q.size();
    @(posedge serial_clk);
    if (fl) begin
      q.delete();
      m_sound = '0;
      m_run = 0;
    end else begin
      if (frame) begin
        if (!m_run) begin
          if (pre >= PL) begin
            m_sound = q.pop_front();
            m_run = 1;
          end else begin
            m_sound = '0;
          end
        end else if (pre > 0) begin
          m_sound = q.pop_front();
        end else begin
          if (m_und != 16'hFFFF) m_und = m_und + 16'd1;
`ifndef I2S_FEEDER_HOLD_LAST_EN
          m_sound = '0;
`endif
        end
      end
      if (push) q.push_back(d);
    end
    m_ws_prev = word_select;
    #1;
    if (ws_run) phase = (phase + 1) % FRAME;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec(), mdl_vec());
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_prime_hold();
    do_reset();
    ws_run = 1;
    for (int i = 0; i < 3 + 3 * FRAME; i++) begin
      cyc(i < 3, 16'($urandom), 0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL prime_cycle t=%0t got=%h exp=%h", $time, dut_vec(), mdl_vec());
      end
    end
    n_checks++;
    if (playing !== 1'b0 || sound_out !== 16'h0 || underrun_count !== 16'h0 || fifo_level !== LW'(3)) begin
      n_fail++;
      $display("FAIL prime_hold got=%b/%h/%h/%0d exp=0/0000/0000/3",
               playing, sound_out, underrun_count, fifo_level);
    end
  endtask

  task automatic test_play_order();
    logic [15:0] vals[4];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_reset();
    ws_run = 1;
    for (int i = 0; i < 4; i++) cyc(1, vals[i], 0);
    while (phase != 0) begin
      cyc(0, '0, 0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL order_cycle t=%0t got=%h exp=%h", $time, dut_vec(), mdl_vec());
      end
    end
    n_checks++;
    if (sound_out !== 16'h0) begin
      n_fail++;
      $display("FAIL order_before got=%h exp=0000", sound_out);
    end
    cyc(0, '0, 0);
    n_checks++;
    if (sound_out !== 16'h1111 || playing !== 1'b1) begin
      n_fail++;
      $display("FAIL order_first got=%h/%b exp=1111/1", sound_out, playing);
    end
    for (int i = 0; i < FRAME - 1; i++) begin
      cyc(0, '0, 0);
      n_checks++;
      if (sound_out !== 16'h1111 || dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL order_stable t=%0t got=%h exp=%h", $time, dut_vec(), mdl_vec());
      end
    end
    cyc(0, '0, 0);
    n_checks++;
    if (sound_out !== 16'h2222) begin
      n_fail++;
      $display("FAIL order_second got=%h exp=2222", sound_out);
    end
  endtask

  task automatic test_fill_full();
    logic [15:0] d;
    do_reset();
    ws_run = 0;
    acc.delete();
    for (int i = 0; i < DEPTH + 4; i++) begin
      d = 16'($urandom);
      if (q.size() < DEPTH) acc.push_back(d);
      cyc(1, d, 0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL fill_cycle t=%0t got=%h exp=%h", $time, dut_vec(), mdl_vec());
      end
    end
    n_checks++;
    if (fifo_level !== LW'(DEPTH) || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full got=%0d/%b exp=%0d/0", fifo_level, in_ready, DEPTH);
    end
  endtask

  task automatic test_underrun();
    logic [15:0] exp_sound;
    in_valid = 1'b0;
    ws_run = 1;
    phase = 0;
    for (int i = 0; i < 19 * FRAME + 1; i++) begin
      cyc(0, '0, 0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL drain_cycle t=%0t got=%h exp=%h", $time, dut_vec(), mdl_vec());
      end
    end
`ifdef I2S_FEEDER_HOLD_LAST_EN
    exp_sound = acc[$];
`else
    exp_sound = 16'h0;
`endif
    n_checks++;
    if (underrun_count !== 16'd3 || sound_out !== exp_sound || playing !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun got=%0d/%h/%b exp=3/%h/1", underrun_count, sound_out, playing, exp_sound);
    end
  endtask

  task automatic test_flush_frame();
    logic [15:0] und_before;
    for (int i = 0; i < 6; i++) cyc(1, 16'($urandom), 0);
    while (phase != 0) begin
      cyc(0, '0, 0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL flush_cycle t=%0t got=%h exp=%h", $time, dut_vec(), mdl_vec());
      end
    end
    und_before = m_und;
    cyc(1, 16'hBEEF, 1);
    n_checks++;
    if (fifo_level !== '0 || playing !== 1'b0 || sound_out !== 16'h0 ||
        underrun_count !== und_before || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_frame got=%0d/%b/%h/%0d/%b exp=0/0/0000/%0d/0",
               fifo_level, playing, sound_out, underrun_count, in_ready, und_before);
    end
    cyc(0, '0, 0);
    n_checks++;
    if (fifo_level !== '0 || in_ready !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_fail++;
      $display("FAIL flush_drop got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 5; i++) cyc(1, 16'($urandom), 0);
    while (phase != 20) cyc(0, '0, 0);
    n_checks++;
    if (fifo_level !== LW'(5)) begin
      n_fail++;
      $display("FAIL midframe_level got=%0d exp=5", fifo_level);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (sound_out !== 16'h0 || fifo_level !== '0 || playing !== 1'b0 || underrun_count !== 16'h0) begin
      n_fail++;
      $display("FAIL midframe_reset got=%h/%0d/%b/%h exp=0000/0/0/0000",
               sound_out, fifo_level, playing, underrun_count);
    end
    model_reset();
    word_select = 1'b0;
    phase = 0;
    repeat (2) @(posedge serial_clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4 + 2 * FRAME; i++) begin
      cyc(i < 4, 16'($urandom), 0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL reprime_cycle t=%0t got=%h exp=%h", $time, dut_vec(), mdl_vec());
      end
    end
    n_checks++;
    if (playing !== 1'b1 || underrun_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reprime got=%b/%h exp=1/0000", playing, underrun_count);
    end
  endtask

  task automatic test_random();
    int pcts[4];
    int pct;
    pcts = '{0, 2, 30, 100};
    ws_run = 1;
    for (int s = 0; s < 10; s++) begin
      pct = pcts[$urandom_range(0, 3)];
      for (int i = 0; i < 256; i++) begin
        cyc($urandom_range(0, 99) < pct, 16'($urandom), $urandom_range(0, 799) == 0);
        n_checks++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++;
          $display("FAIL random_cycle t=%0t got=%h exp=%h", $time, dut_vec(), mdl_vec());
        end
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    ws_run = 0;
    test_reset();
    test_prime_hold();
    test_play_order();
    test_fill_full();
    test_underrun();
    test_flush_frame();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
